// File: rtl/stack_arb.sv
// stack_arb: two-requester arbiter that issues push/pop/clear operations to an
// external stack and returns one response per accepted request.
module stack_arb #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    input  logic [1:0]   req_op,
    input  logic [W-1:0] req_data0,
    input  logic [W-1:0] req_data1,
    output logic [1:0]   req_ready,
    input  logic         clr_req,
    output logic         clr_done,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic         rsp_err,
    output logic [W-1:0] rsp_data,
    output logic         stk_en,
    output logic         stk_rw,
    output logic         stk_clear,
    output logic [W-1:0] stk_din,
    input  logic         stk_full,
    input  logic         stk_empty,
    input  logic [W-1:0] stk_dout
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StCapture,
        StResp,
        StClear
    } state_e;

    state_e         state_q, state_d;
    logic           last_q, last_d;      // requester granted most recently
    logic           id_q, id_d;
    logic           op_q, op_d;
    logic [W-1:0]   data_q, data_d;
    logic           err_q, err_d;
    logic [W-1:0]   rdata_q, rdata_d;
    logic [1:0]     grant;
    logic           gnt_id;
    logic [1:0]     ready_raw;

    // State and transaction registers; last-grant pointer resets to 1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            op_q    <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op_q    <= op_d;
            data_q  <= data_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic, arbitration and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        op_d      = op_q;
        data_d    = data_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        grant     = 2'b00;
        gnt_id    = 1'b0;
        ready_raw = 2'b00;
        clr_done  = 1'b0;
        rsp_valid = 1'b0;
        rsp_id    = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        stk_en    = 1'b0;
        stk_rw    = 1'b0;
        stk_clear = 1'b0;
        stk_din   = '0;

        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                end else if (|req_valid) begin
                    if (req_valid == 2'b11) begin
                        grant = last_q ? 2'b01 : 2'b10;
                    end else begin
                        grant = req_valid;
                    end
                    gnt_id    = grant[1];
                    ready_raw = grant;
                    last_d    = gnt_id;
                    id_d      = gnt_id;
                    op_d      = req_op[gnt_id];
                    data_d    = gnt_id ? req_data1 : req_data0;
                    err_d     = 1'b0;
                    rdata_d   = '0;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                // Flags are only trusted here, one cycle after any prior stack access.
                if (op_q ? stk_full : stk_empty) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    stk_en  = 1'b1;
                    stk_rw  = op_q;
                    stk_din = op_q ? data_q : '0;
                    state_d = op_q ? StResp : StCapture;
                end
            end
            StCapture: begin
                rdata_d = stk_dout;
                state_d = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_err   = err_q;
                rsp_data  = rdata_q;
                state_d   = StIdle;
            end
            StClear: begin
                stk_en    = 1'b1;
                stk_clear = 1'b1;
                clr_done  = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // req_ready is combinational from req_valid in IDLE, so mask it while reset is held.
    always_comb begin
        req_ready = rst_n ? ready_raw : 2'b00;
    end

endmodule

// File: tb/tb_stack_arb.sv
// Directed self-checking bench for stack_arb.
module tb_stack_arb;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_op;
    logic [W-1:0] req_data0, req_data1;
    logic [1:0]   req_ready;
    logic         clr_req, clr_done;
    logic         rsp_valid, rsp_id, rsp_err;
    logic [W-1:0] rsp_data;
    logic         stk_en, stk_rw, stk_clear;
    logic [W-1:0] stk_din;
    logic         stk_full, stk_empty;
    logic [W-1:0] stk_dout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stack_arb #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_ready (req_ready),
        .clr_req   (clr_req),
        .clr_done  (clr_done),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .stk_en    (stk_en),
        .stk_rw    (stk_rw),
        .stk_clear (stk_clear),
        .stk_din   (stk_din),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .stk_dout  (stk_dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_op    = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
        clr_req   = 1'b0;
        stk_full  = 1'b0;
        stk_empty = 1'b0;
        stk_dout  = '0;

        // Reset: every output low even with requests pending.
        #12;
        check("rst_ready", req_ready, 2'b00);
        check("rst_en", stk_en, 1'b0);
        check("rst_rsp", rsp_valid, 1'b0);
        check("rst_din", stk_din, 8'h00);
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();

        // Requester 0 pushes 0xA5.
        req_valid = 2'b01; req_op = 2'b01; req_data0 = 8'hA5;
        #1 check("push_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        #1;
        check("push_en", {stk_en, stk_rw, stk_clear}, 3'b110);
        check("push_din", stk_din, 8'hA5);
        check("push_ready_off", req_ready, 2'b00);
        tick();
        check("push_rsp", {rsp_valid, rsp_id, rsp_err}, 3'b100);
        check("push_rsp_data", rsp_data, 8'h00);
        check("push_resp_en", stk_en, 1'b0);
        tick();

        // Requester 1 pops, stack returns 0xA5.
        req_valid = 2'b10; req_op = 2'b00;
        #1 check("pop_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        #1;
        check("pop_en", {stk_en, stk_rw}, 2'b10);
        check("pop_din", stk_din, 8'h00);
        tick();
        stk_dout = 8'hA5;
        check("pop_cap_rsp", rsp_valid, 1'b0);
        check("pop_cap_en", stk_en, 1'b0);
        tick();
        stk_dout = 8'h00;
        #1;
        check("pop_rsp", {rsp_valid, rsp_id, rsp_err}, 3'b110);
        check("pop_rsp_data", rsp_data, 8'hA5);
        tick();

        // Both hold pops: grants alternate 0,1,0,1.
        req_valid = 2'b11; req_op = 2'b00;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("rr_grant%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            tick();
            tick();
            check($sformatf("rr_rsp_id%0d", i), {rsp_valid, rsp_id}, {1'b1, 1'(i % 2)});
            tick();
        end
        req_valid = 2'b00;

        // Pop on empty -> refused.
        stk_empty = 1'b1;
        req_valid = 2'b01; req_op = 2'b00;
        tick();
        req_valid = 2'b00;
        check("empty_en", stk_en, 1'b0);
        tick();
        check("empty_rsp", {rsp_valid, rsp_id, rsp_err}, 3'b101);
        check("empty_data", rsp_data, 8'h00);
        tick();
        stk_empty = 1'b0;

        // Push on full -> refused.
        stk_full = 1'b1;
        req_valid = 2'b10; req_op = 2'b10; req_data1 = 8'h3C;
        tick();
        req_valid = 2'b00;
        check("full_en", stk_en, 1'b0);
        check("full_din", stk_din, 8'h00);
        tick();
        check("full_rsp", {rsp_valid, rsp_id, rsp_err}, 3'b111);
        tick();
        stk_full = 1'b0;

        // Clear and requests in the same IDLE cycle: clear wins.
        clr_req = 1'b1; req_valid = 2'b11; req_op = 2'b00;
        #1 check("clr_ready", req_ready, 2'b00);
        tick();
        clr_req = 1'b0;
        #1;
        check("clr_ctl", {stk_en, stk_clear, clr_done}, 3'b111);
        check("clr_ready_off", req_ready, 2'b00);
        tick();
        // Last grant was requester 1, so requester 0 wins now.
        check("post_clr_ready", req_ready, 2'b01);
        check("post_clr_done", clr_done, 1'b0);

        // Reset in CAPTURE drops the pop.
        tick();
        check("rc_issue_en", stk_en, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rc_en", stk_en, 1'b0);
        check("rc_ready", req_ready, 2'b00);
        check("rc_rsp", rsp_valid, 1'b0);
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rc_no_rsp%0d", i), rsp_valid, 1'b0);
        end
        // Pointer back to 1 after reset: requester 0 wins a tie.
        req_valid = 2'b11;
        #1 check("rc_ptr", req_ready, 2'b01);
        req_valid = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stack_arb.md
STACK_ARB -- requirements
Module: stack_arb

Interface
REQ-001 Parameter W, default 8, data width; SHALL match the width of the controlled stack.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request strobe (bit n = requester n).
REQ-005 req_op  input  2  per-requester op; 1 = push, 0 = pop.
REQ-006 req_data0, req_data1  input  W each  push data for requester 0 and requester 1.
REQ-007 req_ready  output  2  one-hot accept pulse for the granted requester.
REQ-008 clr_req  input  1  request to clear the stack.
REQ-009 clr_done  output  1  one-cycle pulse when a clear has been issued.
REQ-010 rsp_valid  output  1  one-cycle response pulse.
REQ-011 rsp_id  output  1  requester the response belongs to.
REQ-012 rsp_err  output  1  1 = push refused on full, or pop refused on empty.
REQ-013 rsp_data  output  W  popped word; 0 for push and error responses.
REQ-014 stk_en, stk_rw, stk_clear  output  1 each  stack control; rw 1 = write, 0 = read.
REQ-015 stk_din  output  W  stack write data.
REQ-016 stk_full, stk_empty  input  1 each  stack status flags.
REQ-017 stk_dout  input  W  stack read data, valid in the cycle after the read edge.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, CAPTURE, RESP and CLEAR.
REQ-019 IDLE: clr_req=1 SHALL go to CLEAR and take priority over any req_valid.
REQ-020 IDLE with no clear and at least one req_valid bit set SHALL grant exactly one requester, pulse its req_ready bit, latch its id/op/data, and go to ISSUE.
REQ-021 Arbitration: a lone request SHALL be granted; when both request, the requester not granted last SHALL win; the last-grant pointer SHALL reset to 1 so that requester 0 wins first.
REQ-022 ISSUE, push with stk_full=0, or pop with stk_empty=0: the block SHALL drive stk_en=1, stk_rw=op, and stk_din=latched data (0 for pop) for exactly one cycle.
REQ-023 ISSUE, push then goes to RESP; pop then goes to CAPTURE.
REQ-024 ISSUE, push with stk_full=1, or pop with stk_empty=1: stk_en SHALL stay 0, the error flag SHALL be set, and the FSM SHALL go to RESP.
REQ-025 CAPTURE SHALL register stk_dout into rsp_data and go to RESP.
REQ-026 RESP SHALL pulse rsp_valid with rsp_id, rsp_err and rsp_data held, then return to IDLE.
REQ-027 CLEAR SHALL drive stk_en=1 and stk_clear=1 for one cycle, pulse clr_done, and return to IDLE.
REQ-028 Latency from accept (req_ready) to rsp_valid SHALL be 2 cycles for a push or an error, and 3 cycles for a pop.
REQ-029 Request throughput SHALL be at most one request per 3 cycles (push) or 4 cycles (pop); requests not granted SHALL be held by the requester, and the block SHALL NOT buffer them.
REQ-030 stk_en, stk_clear, req_ready, clr_done and rsp_valid SHALL be zero outside their defined state.
REQ-031 Full and empty flags SHALL be sampled only in ISSUE, after the previous operation has settled.
REQ-032 A clr_req asserted while the FSM is not in IDLE SHALL be held by the requester until IDLE; the block SHALL NOT abort an in-flight operation.

Reset
REQ-033 When rst_n=0, all outputs SHALL be 0, the state SHALL be IDLE, the last-grant pointer SHALL be 1, and all latched data SHALL be 0, with immediate (asynchronous) effect.
REQ-034 A reset during ISSUE or CAPTURE SHALL drop the transaction without producing a response; stack contents are not restored.

Verification
REQ-035 After reset, requester 0 pushes 0xA5 -> req_ready=01, stk_en/stk_rw=1 with stk_din=0xA5 one cycle later, and rsp_valid with id0, err0, data 0x00 one cycle after that.
REQ-036 Requester 1 pops after that push -> stk_en=1 with stk_rw=0, then rsp_valid with id1, err0, rsp_data=0xA5 three cycles after accept.
REQ-037 Both requesters hold pops continuously -> grants alternate 0,1,0,1.
REQ-038 Pop on an empty stack, or push on a full stack (after 8 pushes with H=3) -> stk_en stays 0 and rsp_err=1.
REQ-039 clr_req and req_valid=11 asserted in the same IDLE cycle -> CLEAR is taken first (stk_clear pulse, clr_done), and the request is granted on the next IDLE cycle.
REQ-040 rst_n pulled low in CAPTURE -> all outputs are 0 immediately, and no rsp_valid follows.
